// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle instruction sequencer for the ALU.
//
// Each instruction passes through FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// The ALU sees the instruction only during EXECUTE. In every other state it
// gets a flag-neutral NOP. The ALU's post-condition opcode decides whether
// the instruction writes back, jumps or halts.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start, start_pc     launch execution from IDLE or HALT
//   imem_req/addr       instruction fetch request and address (= pc)
//   imem_rdata/valid    fetched word and its valid strobe
//   alu_instr           instruction presented to the ALU
//   alu_result          ALU result, combinational from alu_instr
//   alu_mod_opcode      ALU opcode after the condition check (F = squashed)
//   rf_raddr1/2         register-file read addresses (rs1, rs2)
//   rf_waddr/wdata/we   register-file writeback port
//   pc, busy, halted    status
//   retired             saturating count of completed instructions
module alu_sequencer #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_pc,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  output logic [31:0]      alu_instr,
  input  logic [31:0]      alu_result,
  input  logic [3:0]       alu_mod_opcode,
  output logic [3:0]       rf_raddr1,
  output logic [3:0]       rf_raddr2,
  output logic [3:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             rf_we,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  // Condition "always", flags untouched, opcode F: leaves the ALU flags alone.
  localparam logic [31:0] ALU_NOP = 32'h0F00_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t           state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [31:0]      ir_reg, ir_next;
  logic [31:0]      res_reg, res_next;
  logic [3:0]       op_reg, op_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic [PC_W-1:0]  jump_target;
  logic             op_writes;

  // The jump target field ir[18:3] is fitted to the pc width.
  generate
    if (PC_W == 16) begin : g_jt_eq
      assign jump_target = ir_reg[18:3];
    end else if (PC_W > 16) begin : g_jt_ext
      assign jump_target = {{(PC_W-16){1'b0}}, ir_reg[18:3]};
    end else begin : g_jt_trunc
      assign jump_target = ir_reg[PC_W+2:3];
    end
  endgenerate

  // Opcodes 0..A and C produce a register result; B, D, E and F do not.
  assign op_writes = (op_reg <= 4'hA) || (op_reg == 4'hC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      pc_reg      <= '0;
      ir_reg      <= '0;
      res_reg     <= '0;
      op_reg      <= 4'hF;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      res_reg     <= res_next;
      op_reg      <= op_next;
      retired_reg <= retired_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    res_next     = res_reg;
    op_next      = op_reg;
    retired_next = retired_reg;
    case (state_reg)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_next    = start_pc;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_next    = imem_rdata;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        res_next   = alu_result;
        op_next    = alu_mod_opcode;
        state_next = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (retired_reg != '1) begin
          retired_next = retired_reg + CNT_W'(1);
        end
        state_next = S_FETCH;
        case (op_reg)
          4'hD:    pc_next = jump_target;
          4'hE:    state_next = S_HALT;
          default: pc_next = pc_reg + PC_W'(1);
        endcase
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign imem_req  = (state_reg == S_FETCH);
  assign imem_addr = pc_reg;
  assign alu_instr = (state_reg == S_EXECUTE) ? ir_reg : ALU_NOP;
  assign rf_raddr1 = ir_reg[18:15];
  assign rf_raddr2 = ir_reg[14:11];
  assign rf_waddr  = ir_reg[22:19];
  assign rf_wdata  = res_reg;
  assign rf_we     = (state_reg == S_WRITEBACK) && op_writes;
  assign pc        = pc_reg;
  assign busy      = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                     (state_reg == S_EXECUTE) || (state_reg == S_WRITEBACK);
  assign halted    = (state_reg == S_HALT);
  assign retired   = retired_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: instruction memory with programmable wait states,
// a small ALU and register file as environment, and an instruction-level
// model that predicts, per retired instruction, the fetch address, the
// writeback and the architectural state afterwards.
module tb_alu_sequencer;

  localparam logic [31:0] NOP = 32'h0F00_0000;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] start_pc;
  logic        imem_req, imem_valid, rf_we, busy, halted;
  logic [15:0] imem_addr, pc;
  logic [31:0] imem_rdata, alu_instr, alu_result, rf_wdata;
  logic [3:0]  alu_mod_opcode, rf_raddr1, rf_raddr2, rf_waddr, retired;

  alu_sequencer #(.PC_W(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .alu_instr(alu_instr), .alu_result(alu_result),
    .alu_mod_opcode(alu_mod_opcode), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we), .pc(pc),
    .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- environment: instruction memory ----------------
  logic [31:0] imem [0:65535];
  int          wait_n = 0;
  int          wait_cnt = 0;
  logic        force_valid = 1'b0;

  assign imem_rdata = imem[imem_addr];
  assign imem_valid = force_valid || (imem_req && (wait_cnt >= wait_n));

  always @(posedge clk) begin
    if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // ---------------- environment: ALU and register file ----------------
  logic [31:0] regs [0:15];
  logic        env_z = 1'b0;
  logic        pre_we = 1'b0;
  logic [3:0]  pre_a = 4'h0;
  logic [31:0] pre_d = 32'h0;
  logic [3:0]  a_op, a_cond;
  logic        a_pass;

  always_comb begin
    a_op   = alu_instr[27:24];
    a_cond = alu_instr[31:28];
    a_pass = (a_cond == 4'h0) || (a_cond == 4'h1 && env_z) || (a_cond == 4'h2 && !env_z);
    alu_mod_opcode = a_pass ? a_op : 4'hF;
    case (a_op)
      4'h0:    alu_result = regs[alu_instr[18:15]] + regs[alu_instr[14:11]];
      4'h1:    alu_result = regs[alu_instr[18:15]] - regs[alu_instr[14:11]];
      4'h2:    alu_result = {16'h0, alu_instr[18:3]};
      default: alu_result = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (alu_mod_opcode == 4'hB) env_z <= (regs[alu_instr[18:15]] == regs[alu_instr[14:11]]);
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    else if (pre_we) regs[pre_a] <= pre_d;
  end

  // ---------------- instruction-level reference model ----------------
  typedef struct {
    logic [15:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [15:0] next_pc;
    logic        halt;
    logic [3:0]  retired;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] m_regs [0:15];
  logic        m_z = 1'b0;
  int          m_retired = 0;
  logic        allow_extra = 1'b0;
  logic        active = 1'b0;
  int          due = 0;

  function automatic logic [31:0] enc(input logic [3:0] cond, input logic [3:0] op,
                                      input logic [3:0] rd, input logic [3:0] rs1,
                                      input logic [3:0] rs2);
    return {cond, op, 1'b0, rd, rs1, rs2, 11'd0};
  endfunction

  function automatic logic [31:0] enc_imm(input logic [3:0] cond, input logic [3:0] op,
                                          input logic [3:0] rd, input logic [15:0] imm);
    return {cond, op, 1'b0, rd, imm, 3'd0};
  endfunction

  // Architectural execution: what each instruction must do, one at a time.
  task automatic model_run(input logic [15:0] spc, input int max_n);
    logic [15:0] p;
    logic [31:0] w, a, b;
    logic [3:0]  op, cond, mop;
    logic        pass;
    exp_t        e;
    p = spc;
    e.halt = 1'b0;
    exp_q.delete();
    for (int n = 0; n < max_n; n++) begin
      w    = imem[p];
      op   = w[27:24];
      cond = w[31:28];
      pass = (cond == 4'h0) || (cond == 4'h1 && m_z) || (cond == 4'h2 && !m_z);
      mop  = pass ? op : 4'hF;
      a    = m_regs[w[18:15]];
      b    = m_regs[w[14:11]];
      e.pc = p; e.instr = w; e.waddr = w[22:19]; e.halt = 1'b0;
      e.next_pc = p + 16'd1;
      e.we = (mop <= 4'hA) || (mop == 4'hC);
      case (mop)
        4'h0:    e.wdata = a + b;
        4'h1:    e.wdata = a - b;
        4'h2:    e.wdata = {16'h0, w[18:3]};
        default: e.wdata = 32'h0;
      endcase
      if (mop == 4'hB) m_z = (a == b);
      if (mop == 4'hD) e.next_pc = w[18:3];
      if (mop == 4'hE) begin e.halt = 1'b1; e.next_pc = p; end
      if (e.we) m_regs[e.waddr] = e.wdata;
      if (m_retired < 15) m_retired++;
      e.retired = 4'(m_retired);
      exp_q.push_back(e);
      if (e.halt) break;
      p = e.next_pc;
    end
    allow_extra = !e.halt;
  endtask

  // ---------------- compare process ----------------
  // A handshake in cycle N puts DECODE at N+1, EXECUTE at N+2, WRITEBACK at
  // N+3 and the retired state at N+4.
  always @(negedge clk) begin
    if (active) begin
      if (due > 0) begin
        due--;
        case (due)
          3: begin
            chk("decode_rs1", 32'(rf_raddr1), 32'(cur.instr[18:15]));
            chk("decode_rs2", 32'(rf_raddr2), 32'(cur.instr[14:11]));
          end
          1: begin
            chk("wb_we", 32'(rf_we), 32'(cur.we));
            if (cur.we) begin
              chk("wb_waddr", 32'(rf_waddr), 32'(cur.waddr));
              chk("wb_wdata", rf_wdata, cur.wdata);
            end
          end
          0: begin
            chk("post_pc", 32'(pc), 32'(cur.next_pc));
            chk("post_retired", 32'(retired), 32'(cur.retired));
            chk("post_halted", 32'(halted), 32'(cur.halt));
            chk("post_busy", 32'(busy), 32'(!cur.halt));
          end
          default: ;
        endcase
        if (due == 2) chk("exec_alu_instr", alu_instr, cur.instr);
      end
      if (due != 2) chk("idle_alu_instr", alu_instr, NOP);
      if (due != 1) chk("idle_rf_we", 32'(rf_we), 32'h0);
      if (imem_req && imem_valid) begin
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("fetch_addr", 32'(imem_addr), 32'(cur.pc));
          due = 4;
        end else if (!allow_extra) begin
          chk("unexpected_fetch", 32'(imem_addr), 32'hFFFF_FFFF);
        end
      end else if (imem_req && exp_q.size() > 0) begin
        chk("fetch_wait_addr", 32'(imem_addr), 32'(exp_q[0].pc));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_imem();
    for (int i = 0; i < 65536; i++) imem[i] = NOP;
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_retired = 0;
  endtask

  task automatic run(input logic [15:0] spc, input int max_n, input int waits);
    int c;
    wait_n = waits;
    model_run(spc, max_n);
    active = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; start_pc = spc;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (c < 1000 && (exp_q.size() != 0 || due != 0)) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0 || due != 0) begin
      chk("run_timeout", 32'(exp_q.size() + due), 32'h0);
      exp_q.delete();
      due = 0;
    end
    #1 active = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; start_pc = 16'h0;
    clear_imem();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) set_reg(4'(i), 32'h0);

    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_alu_instr", alu_instr, NOP);

    // ADD r3 = r1 + r2, zero-wait
    set_reg(4'd1, 32'd5);
    set_reg(4'd2, 32'd7);
    imem[0] = enc(4'h0, 4'h0, 4'd3, 4'd1, 4'd2);
    imem[1] = enc(4'h0, 4'hE, 4'd0, 4'd0, 4'd0);
    run(16'h0000, 10, 0);
    chk("add_r3", regs[3], 32'd12);
    chk("add_pc", 32'(pc), 32'h1);
    chk("add_retired", 32'(retired), 32'h2);

    // SUB with three wait states on every fetch
    clear_imem();
    imem[8] = enc(4'h0, 4'h1, 4'd4, 4'd2, 4'd1);
    imem[9] = enc(4'h0, 4'hE, 4'd0, 4'd0, 4'd0);
    run(16'h0008, 10, 3);
    chk("sub_r4", regs[4], 32'd2);

    // conditional execution resolved by the ALU
    clear_imem();
    set_reg(4'd5, 32'd9);
    set_reg(4'd6, 32'd9);
    set_reg(4'd7, 32'd3);
    imem[16'h10] = enc(4'h0, 4'hB, 4'd0, 4'd5, 4'd6);
    imem[16'h11] = enc_imm(4'h1, 4'h2, 4'd8, 16'h1234);
    imem[16'h12] = enc(4'h0, 4'hB, 4'd0, 4'd5, 4'd7);
    imem[16'h13] = enc(4'h1, 4'h0, 4'd9, 4'd5, 4'd6);
    imem[16'h14] = enc(4'h0, 4'hE, 4'd0, 4'd0, 4'd0);
    run(16'h0010, 10, 0);
    chk("cond_mov_r8", regs[8], 32'h1234);
    chk("cond_squash_r9", regs[9], 32'h0);
    chk("cond_pc", 32'(pc), 32'h14);

    // jump, then pc wrap
    clear_imem();
    imem[16'h10] = enc_imm(4'h0, 4'hD, 4'd0, 16'h0040);
    imem[16'h40] = enc(4'h0, 4'hE, 4'd0, 4'd0, 4'd0);
    run(16'h0010, 10, 1);
    chk("jump_pc", 32'(pc), 32'h40);
    imem[16'hFFFF] = enc(4'h0, 4'h0, 4'd10, 4'd1, 4'd2);
    imem[16'h0000] = enc(4'h0, 4'hE, 4'd0, 4'd0, 4'd0);
    run(16'hFFFF, 10, 0);
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_r10", regs[10], 32'd12);

    // restart from HALT at a new address
    imem[16'h20] = enc_imm(4'h0, 4'h2, 4'd11, 16'h0055);
    imem[16'h21] = enc(4'h0, 4'hE, 4'd0, 4'd0, 4'd0);
    run(16'h0020, 10, 0);
    chk("resume_r11", regs[11], 32'h55);
    chk("resume_pc", 32'(pc), 32'h21);
    chk("resume_halted", 32'(halted), 32'h1);

    // retired counter saturation with a self-loop
    do_reset();
    imem[16'h30] = enc_imm(4'h0, 4'hD, 4'd0, 16'h0030);
    run(16'h0030, 17, 0);
    chk("sat_retired", 32'(retired), 32'hF);
    do_reset();

    // reset in the middle of a fetch; late valid and busy-start ignored
    wait_n = 100;
    imem[16'h50] = enc(4'h0, 4'h0, 4'd12, 4'd1, 4'd2);
    @(posedge clk); #1;
    start = 1'b1; start_pc = 16'h0050;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("mf_req", 32'(imem_req), 32'h1);
    chk("mf_addr", 32'(imem_addr), 32'h50);
    @(posedge clk); #1;
    start = 1'b1; start_pc = 16'h0060;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_addr", 32'(imem_addr), 32'h50);
    chk("busy_start_busy", 32'(busy), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mf_rst_req", 32'(imem_req), 32'h0);
    chk("mf_rst_pc", 32'(pc), 32'h0);
    chk("mf_rst_busy", 32'(busy), 32'h0);
    force_valid = 1'b1;
    @(posedge clk); #1;
    force_valid = 1'b0;
    @(negedge clk);
    chk("late_valid_busy", 32'(busy), 32'h0);
    chk("late_valid_alu", alu_instr, NOP);
    @(posedge clk); #1;
    start = 1'b1; reset = 1'b1; start_pc = 16'h0050;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst_wins_busy", 32'(busy), 32'h0);
    chk("rst_wins_req", 32'(imem_req), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
